// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_decoder
//  Purpose  : Decodes PS/2 keyboard frames (scan code set 2) into a
//             "currently held key" view. The raw keyboard clock and data
//             pass through synchronizers, and the clock is also glitch
//             filtered. An 11-bit frame FSM with a watchdog assembles each
//             byte, and E0/F0 prefix handling produces make/break results.
//  Ports    : clk        - system clock, rising edge
//             rst        - asynchronous reset, active low
//             ps2_clk    - raw keyboard clock (asynchronous)
//             ps2_data   - raw keyboard data (asynchronous)
//             key_data   - scan code of the held key (E0 prefix stripped)
//             in_valid   - high while key_data is held
//             key_strobe - one-cycle pulse per accepted make code
//             frame_err  - one-cycle pulse per aborted/rejected frame
//  Params   : FILT_LEN    - equal samples needed to move the filtered clock
//             TIMEOUT_CYC - clk cycles allowed from start bit to stop bit
//  Macro    : PS2_PARITY_CHECK_EN - when defined, frames with even parity
//             over data+parity are rejected in the STOP state
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_data,
  output logic       in_valid,
  output logic       key_strobe,
  output logic       frame_err
);

  localparam int c_FW = $clog2(FILT_LEN + 1);
  localparam int c_TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_FW-1:0] c_FILT_LAST = c_FW'(FILT_LEN - 1);
  localparam logic [c_TW-1:0] c_TMO_LAST  = c_TW'(TIMEOUT_CYC - 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam logic c_PAR_IGNORE = 1'b0;
`else
  localparam logic c_PAR_IGNORE = 1'b1;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic            r_clk_filt;
  logic [c_FW-1:0] r_filt_cnt;
  logic [c_TW-1:0] r_tmo_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_parity;
  logic            r_ext, r_brk;
  logic [7:0]      r_key_data;
  logic            r_in_valid, r_key_strobe, r_frame_err;
  state_t          r_state, w_state_n;

  logic w_clk_diff, w_filt_flip, w_fall, w_tmo, w_par_ok;
  logic w_accept, w_err, w_prefix, w_ext_n, w_brk_n;

  // Two-flop synchronizers; idle bus level is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Filter: the level flips on the FILT_LEN-th consecutive differing sample.
  assign w_clk_diff  = (r_clk_s2 != r_clk_filt);
  assign w_filt_flip = w_clk_diff && (r_filt_cnt == c_FILT_LAST);
  // A falling edge is a flip while the filtered level is still high.
  assign w_fall      = w_filt_flip && r_clk_filt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else if (!w_clk_diff) begin
      r_filt_cnt <= '0;
    end else if (w_filt_flip) begin
      r_filt_cnt <= '0;
      r_clk_filt <= ~r_clk_filt;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  // Watchdog fires on the TIMEOUT_CYC-th cycle spent outside IDLE.
  assign w_tmo    = (r_state != S_IDLE) && (r_tmo_cnt == c_TMO_LAST);
  // Odd parity over 8 data bits plus parity bit is a good frame.
  assign w_par_ok = c_PAR_IGNORE | (^{r_shift, r_parity});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    w_err     = 1'b0;
    if (w_tmo) begin
      // Timeout wins over a coincident clock edge.
      w_state_n = S_IDLE;
      w_err     = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE:   if (!r_dat_s2) w_state_n = S_DATA;
        S_DATA:   if (r_bit_cnt == 3'd7) w_state_n = S_PARITY;
        S_PARITY: w_state_n = S_STOP;
        S_STOP: begin
          w_state_n = S_IDLE;
          if (r_dat_s2 && w_par_ok) w_accept = 1'b1;
          else                      w_err    = 1'b1;
        end
        default:  w_state_n = S_IDLE;
      endcase
    end
  end

  // Frame datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_tmo) r_tmo_cnt <= '0;
      else                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_fall) begin
        case (r_state)
          S_IDLE:   r_bit_cnt <= '0;
          S_DATA: begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_shift   <= {r_dat_s2, r_shift[7:1]};
          end
          S_PARITY: r_parity <= r_dat_s2;
          default:  ;
        endcase
      end
    end
  end

  // Prefix flags: set by E0/F0, cleared by any other byte or any error.
  assign w_prefix = (r_shift == 8'hE0) || (r_shift == 8'hF0);

  always_comb begin
    w_ext_n = r_ext;
    w_brk_n = r_brk;
    if (w_err) begin
      w_ext_n = 1'b0;
      w_brk_n = 1'b0;
    end else if (w_accept) begin
      if (r_shift == 8'hE0) begin
        w_ext_n = 1'b1;
      end else if (r_shift == 8'hF0) begin
        w_brk_n = 1'b1;
      end else begin
        w_ext_n = 1'b0;
        w_brk_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_key_data   <= 8'h00;
      r_in_valid   <= 1'b0;
      r_key_strobe <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_ext        <= w_ext_n;
      r_brk        <= w_brk_n;
      r_frame_err  <= w_err;
      r_key_strobe <= 1'b0;
      if (w_accept && !w_prefix) begin
        if (!r_brk) begin
          // Make code: last key wins.
          r_key_data   <= r_shift;
          r_in_valid   <= 1'b1;
          r_key_strobe <= 1'b1;
        end else if (r_shift == r_key_data) begin
          // Break only releases the key currently held.
          r_in_valid <= 1'b0;
        end
      end
    end
  end

  assign key_data   = r_key_data;
  assign in_valid   = r_in_valid;
  assign key_strobe = r_key_strobe;
  assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_decoder
//  Purpose  : Directed self-checking bench for ps2_key_decoder. A behavioural
//             keyboard model queues expected events (make strobe, frame
//             error, key release) as frames are driven; a monitor pops and
//             compares them when the DUT produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

  localparam int FILT = 4;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [1:0] K_STROBE = 2'd0;
  localparam logic [1:0] K_ERR    = 2'd1;
  localparam logic [1:0] K_REL    = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] key;
    logic       valid;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_data;
  logic       in_valid, key_strobe, frame_err;

  int         n_assert = 0;
  int         n_fail = 0;
  ev_t        q[$];
  logic [7:0] m_key = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_brk = 1'b0;
  logic       prev_strobe = 1'b0, prev_err = 1'b0, prev_valid = 1'b0;

  ps2_key_decoder #(.FILT_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_data   (key_data),
    .in_valid   (in_valid),
    .key_strobe (key_strobe),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [1:0] k, input logic [7:0] key, input logic v);
    ev_t e;
    e.kind  = k;
    e.key   = key;
    e.valid = v;
    q.push_back(e);
  endfunction

  // Keyboard-side behaviour of a well-formed byte.
  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hE0) begin
      // extended prefix: no visible effect
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (!m_brk) begin
      m_key   = b;
      m_valid = 1'b1;
      push(K_STROBE, b, 1'b1);
    end else begin
      if (m_valid && b == m_key) begin
        m_valid = 1'b0;
        push(K_REL, b, 1'b0);
      end
      m_brk = 1'b0;
    end
  endfunction

  function automatic void model_err();
    push(K_ERR, m_key, m_valid);
    m_brk = 1'b0;
  endfunction

  task automatic pop_chk(input string tag, input logic [1:0] kind, output ev_t e);
    n_assert++;
    assert (q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_unexpected: observed queue size %0d expected nonzero", tag, q.size());
    end
    if (q.size() > 0) e = q.pop_front();
    else              e = '0;
    chk({tag, "_kind"}, e.kind, kind);
  endtask

  // Monitor: compares DUT events against the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      prev_strobe = 1'b0;
      prev_err    = 1'b0;
      prev_valid  = 1'b0;
    end else begin
      if (key_strobe) begin
        chk("strobe_one_cycle", prev_strobe, 1'b0);
        pop_chk("strobe", K_STROBE, e);
        chk("strobe_key", key_data, e.key);
        chk("strobe_valid", in_valid, 1'b1);
      end
      if (frame_err) begin
        chk("err_one_cycle", prev_err, 1'b0);
        pop_chk("err", K_ERR, e);
        chk("err_key", key_data, e.key);
        chk("err_valid", in_valid, e.valid);
      end
      if (prev_valid && !in_valid) begin
        pop_chk("release", K_REL, e);
        chk("release_key", key_data, e.key);
      end
      prev_strobe = key_strobe;
      prev_err    = frame_err;
      prev_valid  = in_valid;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    idle(HALF);
    ps2_clk = 1'b0;
    idle(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    if (bad_stop || (PAR_EN && bad_par)) model_err();
    else                                  model_byte(b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(~bad_stop);
    ps2_data = 1'b1;
    idle(40);
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  // Start bit plus n data bits of 1, then the bus stays idle.
  task automatic partial(input int n);
    ps2_bit(1'b0);
    for (int i = 0; i < n; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
  endtask

  initial begin
    idle(3);
    chk("reset_key", key_data, 8'h00);
    chk("reset_valid", in_valid, 1'b0);
    chk("reset_strobe", key_strobe, 1'b0);
    chk("reset_err", frame_err, 1'b0);
    rst = 1'b1;
    idle(10);

    // Make / break of a plain key.
    send(8'h29); send(8'hF0); send(8'h29);
    chk("k29_key", key_data, 8'h29);
    chk("k29_valid", in_valid, 1'b0);

    // Extended key, prefix stripped.
    send(8'hE0); send(8'h75);
    chk("e075_key", key_data, 8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("e075_valid", in_valid, 1'b0);

    // Last key wins; releasing the older key changes nothing.
    send(8'h6B); send(8'h74);
    send(8'hF0); send(8'h6B);
    chk("rollover_key", key_data, 8'h74);
    chk("rollover_valid", in_valid, 1'b1);
    send(8'hF0); send(8'h74);
    chk("rollover_rel", in_valid, 1'b0);

    // Bad stop bit leaves the held key alone; error also clears brk.
    send(8'h1C);
    send_frame(8'h5A, 1'b1, 1'b0);
    send(8'hF0);
    send_frame(8'h1C, 1'b1, 1'b0);
    send(8'h1C);
    chk("brk_cleared_valid", in_valid, 1'b1);
    send(8'hF0); send(8'h1C);

    // Glitch shorter than the filter window must not start a frame.
    ps2_data = 1'b0; ps2_clk = 1'b0;
    idle(2);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    idle(20);
    send(8'h4D);

    // Watchdog abort of a truncated frame, then a clean frame.
    model_err();
    partial(3);
    idle(TMO + 300);
    chk("timeout_drained", q.size(), 0);
    send(8'h72);
    chk("after_tmo_key", key_data, 8'h72);

    // Wrong parity.
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("parity_key", key_data, PAR_EN ? 8'h72 : 8'h5A);

    // Reset mid-frame discards the partial frame and clears outputs.
    partial(4);
    rst = 1'b0;
    #1;
    chk("midrst_key", key_data, 8'h00);
    chk("midrst_valid", in_valid, 1'b0);
    chk("midrst_strobe", key_strobe, 1'b0);
    chk("midrst_err", frame_err, 1'b0);
    q.delete();
    m_key = 8'h00; m_valid = 1'b0; m_brk = 1'b0;
    idle(5);
    rst = 1'b1;
    idle(10);
    send(8'h16);

    chk("final_key", key_data, m_key);
    chk("final_valid", in_valid, m_valid);
    chk("final_queue", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: observed no completion expected finish within 60000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
